// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - state codes, opcodes and A-mux selects for control_unit_v2
package cu_pkg;

  // 5-bit state codes exposed on CheckState; codes 14..31 are unused
  typedef enum logic [4:0] {
    S_START  = 5'd0,
    S_FETCH  = 5'd1,
    S_DECODE = 5'd2,
    S_LOAD   = 5'd3,
    S_STORE  = 5'd4,
    S_ADD    = 5'd5,
    S_SUB    = 5'd6,
    S_INPUT  = 5'd7,
    S_JZ     = 5'd8,
    S_JPOS   = 5'd9,
    S_JNEG   = 5'd10,
    S_JMP    = 5'd11,
    S_NOP    = 5'd12,
    S_HALT   = 5'd13
  } state_t;

  // Opcodes 0-7 keep the legacy 3-bit CU encoding
  localparam int OP_LOAD  = 0;
  localparam int OP_STORE = 1;
  localparam int OP_ADD   = 2;
  localparam int OP_SUB   = 3;
  localparam int OP_INPUT = 4;
  localparam int OP_JZ    = 5;
  localparam int OP_JPOS  = 6;
  localparam int OP_HALT  = 7;
  localparam int OP_JNEG  = 8;
  localparam int OP_JMP   = 9;
  localparam int OP_NOP   = 10;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

endpackage

// File: rtl/edge_detect_rise.sv
// rtl/edge_detect_rise.sv - one-cycle pulse on the rising edge of a level input
module edge_detect_rise (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic rise
);

  logic din_q;

  // Remember last cycle's level so a held input only pulses once
  always_ff @(posedge clk) begin
    if (!resetn) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/control_unit_v2.sv
// rtl/control_unit_v2.sv - multi-cycle control FSM for the accumulator datapath
module control_unit_v2 #(
  parameter int OPW         = 4,
  parameter int MEM_WAIT    = 0,
  parameter int HALT_RESUME = 0
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           Enter,
  input  logic [OPW-1:0] IR,
  input  logic           Aeq0,
  input  logic           Apos,
  output logic           IRload,
  output logic           JMPmux,
  output logic           PCload,
  output logic           Meminst,
  output logic           MemWr,
  output logic [1:0]     Asel,
  output logic           Aload,
  output logic           Sub,
  output logic           Halt,
  output logic           Illegal,
  output logic [4:0]     CheckState
);
  import cu_pkg::*;

  localparam int WW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_WAIT);

  state_t        state;
  state_t        next_state;
  state_t        decode_target;
  logic [WW-1:0] wait_cnt;
  logic          wait_done;
  logic          illegal_q;
  logic          enter_rise;
  logic [31:0]   ir_ext;

  edge_detect_rise u_enter_edge (
    .clk    (Clock),
    .resetn (Resetn),
    .din    (Enter),
    .rise   (enter_rise)
  );

  // Zero-extend so the illegal-opcode test is meaningful for any OPW, including 3
  assign ir_ext    = 32'(IR);
  assign wait_done = (wait_cnt == WAIT_LAST);

  // Map the opcode to its execute state; anything undefined halts
  always_comb begin
    decode_target = S_HALT;
    case (ir_ext)
      OP_LOAD:  decode_target = S_LOAD;
      OP_STORE: decode_target = S_STORE;
      OP_ADD:   decode_target = S_ADD;
      OP_SUB:   decode_target = S_SUB;
      OP_INPUT: decode_target = S_INPUT;
      OP_JZ:    decode_target = S_JZ;
      OP_JPOS:  decode_target = S_JPOS;
      OP_HALT:  decode_target = S_HALT;
      OP_JNEG:  decode_target = S_JNEG;
      OP_JMP:   decode_target = S_JMP;
      OP_NOP:   decode_target = S_NOP;
      default:  decode_target = S_HALT;
    endcase
  end

  // Next-state rules; FETCH and DECODE stretch by the memory wait states
  always_comb begin
    next_state = S_START;
    case (state)
      S_START:  next_state = S_FETCH;
      S_FETCH:  next_state = wait_done ? S_DECODE : S_FETCH;
      S_DECODE: next_state = wait_done ? decode_target : S_DECODE;
      S_INPUT:  next_state = enter_rise ? S_START : S_INPUT;
      S_HALT:   next_state = ((HALT_RESUME != 0) && enter_rise) ? S_START : S_HALT;
      default:  next_state = S_START;
    endcase
  end

  // State register, per-state wait counter and sticky illegal flag
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= S_START;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        wait_cnt <= '0;
      end else if (!wait_done) begin
        wait_cnt <= wait_cnt + WW'(1);
      end
      if ((state == S_DECODE) && wait_done && (ir_ext > 32'(OP_NOP))) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Control decode from state; jump PCload follows the A flags in the same cycle
  always_comb begin
    IRload  = 1'b0;
    JMPmux  = 1'b0;
    PCload  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Asel    = ASEL_ALU;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Halt    = 1'b0;
    case (state)
      S_FETCH: begin
        IRload = wait_done;
        PCload = wait_done;
      end
      S_DECODE: Meminst = 1'b1;
      S_LOAD: begin
        Asel  = ASEL_MEM;
        Aload = 1'b1;
      end
      S_STORE: begin
        Meminst = 1'b1;
        MemWr   = 1'b1;
      end
      S_ADD:   Aload = 1'b1;
      S_SUB: begin
        Aload = 1'b1;
        Sub   = 1'b1;
      end
      S_INPUT: begin
        Asel  = ASEL_IN;
        Aload = 1'b1;
      end
      S_JZ: begin
        JMPmux = 1'b1;
        PCload = Aeq0;
      end
      S_JPOS: begin
        JMPmux = 1'b1;
        PCload = Apos;
      end
      S_JNEG: begin
        JMPmux = 1'b1;
        PCload = ~Aeq0 & ~Apos;
      end
      S_JMP: begin
        JMPmux = 1'b1;
        PCload = 1'b1;
      end
      S_HALT:  Halt = 1'b1;
      default: ;
    endcase
  end

  assign Illegal    = illegal_q;
  assign CheckState = state;

endmodule

// File: tb/tb_control_unit_v2.sv
// tb/tb_control_unit_v2.sv - randomized and directed bench for control_unit_v2
module tb_control_unit_v2;
  import cu_pkg::*;

  logic       clk;
  logic       rstn [2];
  logic       ent  [2];
  logic       aeq0 [2];
  logic       apos [2];
  logic [3:0] ir   [2];
  logic       irl  [2];
  logic       jmx  [2];
  logic       pcl  [2];
  logic       mi   [2];
  logic       mwr  [2];
  logic [1:0] asel [2];
  logic       al   [2];
  logic       sb   [2];
  logic       hl   [2];
  logic       il   [2];
  logic [4:0] cs   [2];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: instruction-relative cycle index plus latched opcode
  int t   [2];
  int op  [2];
  bit ill [2];
  bit eprev [2];
  int mw;
  bit mrise;

  control_unit_v2 #(.OPW(4), .MEM_WAIT(0), .HALT_RESUME(0)) u0 (
    .Clock(clk), .Resetn(rstn[0]), .Enter(ent[0]), .IR(ir[0]), .Aeq0(aeq0[0]), .Apos(apos[0]),
    .IRload(irl[0]), .JMPmux(jmx[0]), .PCload(pcl[0]), .Meminst(mi[0]), .MemWr(mwr[0]),
    .Asel(asel[0]), .Aload(al[0]), .Sub(sb[0]), .Halt(hl[0]), .Illegal(il[0]), .CheckState(cs[0])
  );

  control_unit_v2 #(.OPW(4), .MEM_WAIT(2), .HALT_RESUME(1)) u2 (
    .Clock(clk), .Resetn(rstn[1]), .Enter(ent[1]), .IR(ir[1]), .Aeq0(aeq0[1]), .Apos(apos[1]),
    .IRload(irl[1]), .JMPmux(jmx[1]), .PCload(pcl[1]), .Meminst(mi[1]), .MemWr(mwr[1]),
    .Asel(asel[1]), .Aload(al[1]), .Sub(sb[1]), .Halt(hl[1]), .Illegal(il[1]), .CheckState(cs[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] obs(int d);
    return {irl[d], jmx[d], pcl[d], mi[d], mwr[d], asel[d], al[d], sb[d], hl[d], il[d], cs[d]};
  endfunction

  function automatic logic [15:0] model_out(int d);
    int w;
    logic e_irl, e_jm, e_pc, e_mi, e_mw, e_al, e_sb, e_hl;
    logic [1:0] e_as;
    logic [4:0] st;
    w = (d == 0) ? 0 : 2;
    {e_irl, e_jm, e_pc, e_mi, e_mw, e_al, e_sb, e_hl} = 8'b0;
    e_as = 2'b00;
    if (t[d] == 0) st = S_START;
    else if (t[d] <= w + 1) begin
      st = S_FETCH;
      if (t[d] == w + 1) begin e_irl = 1'b1; e_pc = 1'b1; end
    end else if (t[d] <= 2 * w + 2) begin
      st = S_DECODE; e_mi = 1'b1;
    end else begin
      case (op[d])
        0: begin st = S_LOAD; e_as = 2'b10; e_al = 1'b1; end
        1: begin st = S_STORE; e_mi = 1'b1; e_mw = 1'b1; end
        2: begin st = S_ADD; e_al = 1'b1; end
        3: begin st = S_SUB; e_al = 1'b1; e_sb = 1'b1; end
        4: begin st = S_INPUT; e_as = 2'b01; e_al = 1'b1; end
        5: begin st = S_JZ; e_jm = 1'b1; e_pc = aeq0[d]; end
        6: begin st = S_JPOS; e_jm = 1'b1; e_pc = apos[d]; end
        8: begin st = S_JNEG; e_jm = 1'b1; e_pc = !aeq0[d] && !apos[d]; end
        9: begin st = S_JMP; e_jm = 1'b1; e_pc = 1'b1; end
        10: st = S_NOP;
        default: begin st = S_HALT; e_hl = 1'b1; end
      endcase
    end
    return {e_irl, e_jm, e_pc, e_mi, e_mw, e_as, e_al, e_sb, e_hl, ill[d], st};
  endfunction

  // Advance the reference model on every clock with the inputs the DUTs sampled
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mw = (d == 0) ? 0 : 2;
      mrise = ent[d] && !eprev[d];
      if (!rstn[d]) begin
        t[d] = 0; ill[d] = 0; eprev[d] = 0;
      end else begin
        eprev[d] = ent[d];
        if (t[d] < 2 * mw + 2) t[d]++;
        else if (t[d] == 2 * mw + 2) begin
          op[d] = int'(ir[d]);
          if (op[d] > 10) ill[d] = 1;
          t[d]++;
        end else if (op[d] == 4) begin
          if (mrise) t[d] = 0;
        end else if (op[d] == 7 || op[d] > 10) begin
          if (d == 1 && mrise) t[d] = 0;
        end else t[d] = 0;
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== {11'b0, 5'(S_START)}) begin
          miscompares++;
          $display("FAIL reset_state dut%0d: got %h want %h", d, obs(d), {11'b0, 5'(S_START)});
        end
      end
    end
    @(negedge clk); rstn[1] = 1'b1; ir[1] = 4'd2; #1;
    @(negedge clk); #1;
    vectors++;
    if (cs[1] !== 5'(S_FETCH)) begin
      miscompares++; $display("FAIL reset_prefetch state: got %0d want %0d", cs[1], S_FETCH);
    end
    @(negedge clk); rstn[1] = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (obs(1) !== {11'b0, 5'(S_START)}) begin
        miscompares++; $display("FAIL reset_midfetch cyc%0d: got %h want %h", i, obs(1), {11'b0, 5'(S_START)});
      end
    end
  endtask

  task automatic test_add();
    logic [4:0] exp_st [5];
    exp_st = '{5'(S_START), 5'(S_FETCH), 5'(S_DECODE), 5'(S_ADD), 5'(S_START)};
    @(negedge clk); rstn[0] = 1'b0; ir[0] = 4'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); rstn[0] = 1'b1; #1;
      vectors++;
      if (cs[0] !== exp_st[i] || obs(0) !== model_out(0)) begin
        miscompares++; $display("FAIL add cyc%0d: got %h want %h st %0d", i, obs(0), model_out(0), exp_st[i]);
      end
      if (i == 3) begin
        vectors++;
        if ({al[0], sb[0]} !== 2'b10) begin
          miscompares++; $display("FAIL add_ctrl: Aload/Sub got %b want 10", {al[0], sb[0]});
        end
      end
    end
  endtask

  task automatic test_load_wait();
    logic [4:0] exp_st;
    @(negedge clk); rstn[1] = 1'b0; ir[1] = 4'd0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); rstn[1] = 1'b1; #1;
      exp_st = (i == 0 || i == 8) ? 5'(S_START) : (i <= 3) ? 5'(S_FETCH) : (i <= 6) ? 5'(S_DECODE) : 5'(S_LOAD);
      vectors++;
      if (cs[1] !== exp_st || irl[1] !== (i == 3) || obs(1) !== model_out(1)) begin
        miscompares++; $display("FAIL load_wait cyc%0d: got %h want %h st %0d", i, obs(1), model_out(1), exp_st);
      end
      if (i == 7) begin
        vectors++;
        if (asel[1] !== 2'b10) begin
          miscompares++; $display("FAIL load_asel: got %b want 10", asel[1]);
        end
      end
    end
  endtask

  task automatic test_input();
    int exits = 0;
    logic [4:0] prev = 5'(S_START);
    @(negedge clk); rstn[0] = 1'b0; ir[0] = 4'd4; ent[0] = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk); rstn[0] = 1'b1; ent[0] = (i >= 4 && i <= 8); #1;
      if (prev == 5'(S_INPUT) && cs[0] == 5'(S_START)) exits++;
      prev = cs[0];
      vectors++;
      if (obs(0) !== model_out(0)) begin
        miscompares++; $display("FAIL input cyc%0d: got %h want %h", i, obs(0), model_out(0));
      end
      if (i == 5) begin
        vectors++;
        if (cs[0] !== 5'(S_START)) begin
          miscompares++; $display("FAIL input_exit_cycle: state %0d want %0d", cs[0], S_START);
        end
      end
    end
    vectors++;
    if (exits != 1) begin
      miscompares++; $display("FAIL input_exit_count: got %0d want 1", exits);
    end
    ent[0] = 1'b0;
  endtask

  task automatic test_jumps();
    logic [3:0] codes [3];
    logic       zs [3];
    logic       ps [3];
    logic       want [3];
    codes = '{4'd8, 4'd8, 4'd9};
    zs = '{1'b0, 1'b0, 1'b0};
    ps = '{1'b0, 1'b1, 1'b1};
    want = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); rstn[0] = 1'b0; ir[0] = codes[k]; aeq0[0] = zs[k]; apos[0] = ps[k];
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); rstn[0] = 1'b1; #1;
        vectors++;
        if (obs(0) !== model_out(0)) begin
          miscompares++; $display("FAIL jump%0d cyc%0d: got %h want %h", k, i, obs(0), model_out(0));
        end
      end
      vectors++;
      if ({jmx[0], pcl[0]} !== {1'b1, want[k]}) begin
        miscompares++; $display("FAIL jump%0d_pcload: JMPmux/PCload got %b want %b", k, {jmx[0], pcl[0]}, {1'b1, want[k]});
      end
    end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin rstn[d] = 1'b0; ir[d] = 4'hF; ent[d] = 1'b0; end
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin rstn[d] = 1'b1; ent[d] = (i == 10); end
      #1;
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== model_out(d)) begin
          miscompares++; $display("FAIL illegal dut%0d cyc%0d: got %h want %h", d, i, obs(d), model_out(d));
        end
      end
      if (i == 7) begin
        vectors++;
        if ({cs[1], hl[1], il[1]} !== {5'(S_HALT), 2'b11}) begin
          miscompares++; $display("FAIL illegal_halt: state %0d halt %b illegal %b want 13 1 1", cs[1], hl[1], il[1]);
        end
      end
      if (i == 11) begin
        vectors++;
        if (cs[1] !== 5'(S_START) || il[1] !== 1'b1 || cs[0] !== 5'(S_HALT)) begin
          miscompares++; $display("FAIL illegal_resume: u2 st %0d ill %b u0 st %0d want 0 1 13", cs[1], il[1], cs[0]);
        end
      end
    end
    for (int d = 0; d < 2; d++) ent[d] = 1'b0;
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        rstn[d] = ($urandom_range(0, 39) != 0);
        ent[d]  = ($urandom_range(0, 2) == 0);
        ir[d]   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
        r = $urandom_range(0, 2);
        aeq0[d] = (r == 0);
        apos[d] = (r == 1);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== model_out(d)) begin
          miscompares++; $display("FAIL random dut%0d cyc%0d: got %h want %h", d, i, obs(d), model_out(d));
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; ent[d] = 1'b0; aeq0[d] = 1'b0; apos[d] = 1'b0; ir[d] = 4'd0;
    end
    test_reset();
    test_add();
    test_load_wait();
    test_input();
    test_jumps();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
